// File: rtl/flash_host_bridge.sv
// Host byte-stream front-end for the SPI flash collection block: parses packets, loads and
// drains the collection FIFO through its direct port, and answers with a status byte.
module flash_host_bridge #(
    parameter int unsigned PULSE_LEN   = 4,
    parameter int unsigned FIFO_RD_LAT = 1,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        read,
    output logic        write,
    output logic [7:0]  numByte_read_wp,
    output logic [31:0] numByte_write,
    output logic [23:0] address_wp,
    output logic        direct_fifo,
    output logic [7:0]  direct_buf_in,
    output logic        direct_wr_en_buf,
    output logic        direct_rd_en_buf,
    input  logic [7:0]  direct_buf_out,
    input  logic        cs_bar,
    output logic        busy
);

    localparam int unsigned TMR_MAX = (TIMEOUT > PULSE_LEN + FIFO_RD_LAT) ?
                                      TIMEOUT : PULSE_LEN + FIFO_RD_LAT;
    localparam int unsigned TW = $clog2(TMR_MAX + 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ST_OK    = 8'hAA;
    localparam logic [7:0] ST_BAD   = 8'h3F;
    localparam logic [7:0] ST_TMO   = 8'hEE;

    typedef enum logic [3:0] {
        StIdle, StAddr, StLen, StLoad, StStart, StWaitLow, StWaitHigh,
        StPop, StCapture, StSend, StResp
    } state_t;

    state_t        state_q, state_d;
    logic          is_read_q, is_read_d;
    logic [23:0]   addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    tx_q, tx_d;
    logic          cs_meta_q, cs_sync_q;
    logic          rx_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            is_read_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            tx_q      <= '0;
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            tx_q      <= tx_d;
            cs_meta_q <= cs_bar;
            cs_sync_q <= cs_meta_q;
        end
    end

    assign rx_take = rx_valid && rx_ready;

    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        unique case (state_q)
            StIdle: begin
                if (rx_take) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_read_d = (rx_data == OP_READ);
                        cnt_d     = '0;
                        state_d   = StAddr;
                    end else begin
                        tx_d    = ST_BAD;
                        state_d = StResp;
                    end
                end
            end
            StAddr: begin
                if (rx_take) begin
                    addr_d = {addr_q[15:0], rx_data};
                    cnt_d  = cnt_q + 9'd1;
                    if (cnt_q == 9'd2) state_d = StLen;
                end
            end
            StLen: begin
                if (rx_take) begin
                    if (rx_data == 8'h00) begin
                        tx_d    = ST_BAD;
                        state_d = StResp;
                    end else begin
                        len_d   = rx_data;
                        cnt_d   = '0;
                        state_d = is_read_q ? StStart : StLoad;
                    end
                end
            end
            StLoad: begin
                if (rx_take) begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_d == {1'b0, len_q}) state_d = StStart;
                end
            end
            // First START cycle is a setup cycle so address/length lead the request edge.
            StStart: begin
                if (tmr_q == TW'(PULSE_LEN)) state_d = StWaitLow;
            end
            StWaitLow: begin
                if (!cs_sync_q) begin
                    state_d = StWaitHigh;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    tx_d    = ST_TMO;
                    state_d = StResp;
                end
            end
            StWaitHigh: begin
                if (cs_sync_q) begin
                    if (is_read_q) begin
                        cnt_d   = '0;
                        state_d = StPop;
                    end else begin
                        tx_d    = ST_OK;
                        state_d = StResp;
                    end
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    tx_d    = ST_TMO;
                    state_d = StResp;
                end
            end
            StPop: begin
                cnt_d   = cnt_q + 9'd1;
                state_d = StCapture;
            end
            StCapture: begin
                if (tmr_q == TW'(FIFO_RD_LAT - 1)) begin
                    tx_d    = direct_buf_out;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    if (cnt_q < {1'b0, len_q}) begin
                        state_d = StPop;
                    end else begin
                        tx_d    = ST_OK;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (tx_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // One shared timer, restarted on every state entry.
        tmr_d = (state_d != state_q) ? '0 : tmr_q + TW'(1);
    end

    // Strobes decode straight from the state flops so reset removes them immediately.
    assign rx_ready = (state_q == StIdle) || (state_q == StAddr) ||
                      (state_q == StLen)  || (state_q == StLoad);
    assign tx_valid = (state_q == StSend) || (state_q == StResp);
    assign tx_data  = tx_q;
    assign read     = (state_q == StStart) && (tmr_q != '0) && is_read_q;
    assign write    = (state_q == StStart) && (tmr_q != '0) && !is_read_q;

    assign direct_fifo      = (state_q == StLoad) || (state_q == StPop) ||
                              (state_q == StCapture) || (state_q == StSend);
    assign direct_wr_en_buf = (state_q == StLoad) && rx_valid;
    assign direct_buf_in    = direct_wr_en_buf ? rx_data : 8'h00;
    assign direct_rd_en_buf = (state_q == StPop);

    assign numByte_read_wp = len_q;
    assign numByte_write   = {24'b0, len_q};
    assign address_wp      = addr_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_flash_host_bridge.sv
// Directed bench for flash_host_bridge: host packets in, flash CS and FIFO modelled,
// response stream and request/strobe activity checked against hand-computed values.
module tb_flash_host_bridge;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        read;
    logic        write;
    logic [7:0]  numByte_read_wp;
    logic [31:0] numByte_write;
    logic [23:0] address_wp;
    logic        direct_fifo;
    logic [7:0]  direct_buf_in;
    logic        direct_wr_en_buf;
    logic        direct_rd_en_buf;
    logic [7:0]  direct_buf_out;
    logic        cs_bar;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flash_host_bridge #(
        .PULSE_LEN  (4),
        .FIFO_RD_LAT(1),
        .TIMEOUT    (100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .read            (read),
        .write           (write),
        .numByte_read_wp (numByte_read_wp),
        .numByte_write   (numByte_write),
        .address_wp      (address_wp),
        .direct_fifo     (direct_fifo),
        .direct_buf_in   (direct_buf_in),
        .direct_wr_en_buf(direct_wr_en_buf),
        .direct_rd_en_buf(direct_rd_en_buf),
        .direct_buf_out  (direct_buf_out),
        .cs_bar          (cs_bar),
        .busy            (busy)
    );

    // Monitors and FIFO model; the main block only writes mem[] and mon_clr.
    logic       mon_clr;
    logic [7:0] mem [0:15];
    logic [7:0] push_log [0:15];
    int         cyc = 0;
    int         wr_hi, rd_hi, push_n, pops, stall_err, rptr;
    logic       stall_prev, pend;
    logic [7:0] stall_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_hi <= 0; rd_hi <= 0; push_n <= 0; pops <= 0; stall_err <= 0;
            stall_prev <= 1'b0; pend <= 1'b0; stall_data <= 8'h00;
        end else begin
            if (write) wr_hi <= wr_hi + 1;
            if (read) rd_hi <= rd_hi + 1;
            if (direct_wr_en_buf) begin
                push_log[push_n[3:0]] <= direct_buf_in;
                push_n <= push_n + 1;
            end
            pend <= direct_rd_en_buf;
            if (direct_rd_en_buf) pops <= pops + 1;
            if (stall_prev && tx_data !== stall_data) stall_err <= stall_err + 1;
            stall_prev <= tx_valid && !tx_ready;
            stall_data <= tx_data;
        end
    end

    always @(posedge clk) begin
        if (mon_clr) rptr <= 0;
        else if (pend) begin
            direct_buf_out <= mem[rptr[3:0]];
            rptr <= rptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic send_pkt(input bq_t q);
        foreach (q[i]) begin
            bit accepted = 1'b0;
            rx_data  = q[i];
            rx_valid = 1'b1;
            for (int n = 0; n < 100 && !accepted; n++) begin
                @(negedge clk);
                accepted = rx_ready;
                tick();
            end
            rx_valid = 1'b0;
            check("rx_accept", accepted, 1);
        end
    endtask

    task automatic recv(input bit bp, output logic [7:0] b);
        bit got = 1'b0;
        b = 'x;
        tx_ready = bp ? (cyc % 4 == 0) : 1'b1;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                b   = tx_data;
                got = 1'b1;
            end
            tick();
            tx_ready = got ? 1'b0 : (bp ? (cyc % 4 == 0) : 1'b1);
        end
        tx_ready = 1'b0;
    endtask

    // Flash model: wait for the request pulse, then drive a CS low/high window.
    task automatic do_cs(input bit rd, input logic [23:0] a, input logic [7:0] len,
                         input int d1, input int d2);
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = rd ? read : write;
        end
        check("pulse_seen", seen, 1);
        check("addr_at_rise", address_wp, a);
        check("nbr_at_rise", numByte_read_wp, len);
        check("nbw_at_rise", numByte_write, {24'b0, len});
        check("dfifo_at_rise", direct_fifo, 0);
        for (int n = 0; n < 50 && (read || write); n++) @(negedge clk);
        tick();
        repeat (d1) tick();
        cs_bar = 1'b0;
        repeat (d2) tick();
        cs_bar = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        bq_t        pkt;
        int         k;
        bit         seen;

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; cs_bar = 1'b1;
        mon_clr = 1'b0; direct_buf_out = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) tick();
        check("rst_rx_ready", rx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_dfifo", direct_fifo, 0);
        check("rst_wr_en", direct_wr_en_buf, 0);
        check("rst_rd_en", direct_rd_en_buf, 0);
        check("rst_addr", address_wp, 0);
        check("rst_nbw", numByte_write, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Write of two bytes
        clr_mon();
        pkt = '{8'h57, 8'h01, 8'h02, 8'h03, 8'h02, 8'hA5, 8'h5A};
        send_pkt(pkt);
        do_cs(1'b0, 24'h010203, 8'h02, 5, 20);
        recv(1'b0, b);
        check("wr_status", b, 8'hAA);
        check("wr_busy_after", busy, 0);
        check("wr_pulse_len", wr_hi, 4);
        check("wr_no_read", rd_hi, 0);
        check("wr_push_n", push_n, 2);
        check("wr_push0", push_log[0], 8'hA5);
        check("wr_push1", push_log[1], 8'h5A);
        check("wr_no_pop", pops, 0);

        // Read of three bytes, free-flowing sink
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        clr_mon();
        pkt = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h03};
        send_pkt(pkt);
        do_cs(1'b1, 24'h000010, 8'h03, 10, 50);
        recv(1'b0, b); check("rd_b0", b, 8'h11);
        recv(1'b0, b); check("rd_b1", b, 8'h22);
        recv(1'b0, b); check("rd_b2", b, 8'h33);
        recv(1'b0, b); check("rd_status", b, 8'hAA);
        check("rd_pops", pops, 3);
        check("rd_pulse_len", rd_hi, 4);
        check("rd_no_write", wr_hi, 0);
        check("rd_no_push", push_n, 0);
        check("rd_busy_after", busy, 0);

        // Same read with a sink ready one cycle in four
        clr_mon();
        send_pkt(pkt);
        do_cs(1'b1, 24'h000010, 8'h03, 10, 50);
        recv(1'b1, b); check("bp_b0", b, 8'h11);
        recv(1'b1, b); check("bp_b1", b, 8'h22);
        recv(1'b1, b); check("bp_b2", b, 8'h33);
        recv(1'b1, b); check("bp_status", b, 8'hAA);
        check("bp_pops", pops, 3);
        check("bp_stable", stall_err, 0);

        // Illegal opcode and zero length
        clr_mon();
        pkt = '{8'h41};
        send_pkt(pkt);
        recv(1'b0, b); check("bad_op", b, 8'h3F);
        pkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        recv(1'b0, b); check("zero_len", b, 8'h3F);
        check("zero_len_no_write", wr_hi, 0);
        check("bad_busy_after", busy, 0);

        // CS never moves: timeout after 100 cycles in WAIT_LOW
        clr_mon();
        pkt = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h01};
        send_pkt(pkt);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = read;
        end
        check("tmo_pulse_seen", seen, 1);
        for (int n = 0; n < 50 && read; n++) @(negedge clk);
        k = 0;
        for (int n = 0; n < 300 && !tx_valid; n++) begin
            k++;
            @(negedge clk);
        end
        check("tmo_cycles", k, 100);
        tick();
        recv(1'b0, b); check("tmo_status", b, 8'hEE);
        check("tmo_no_pop", pops, 0);
        check("tmo_pulse_len", rd_hi, 4);

        // Async reset in the middle of a payload load
        clr_mon();
        pkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'hAA};
        send_pkt(pkt);
        check("mid_dfifo", direct_fifo, 1);
        check("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_dfifo", direct_fifo, 0);
        check("arst_busy", busy, 0);
        check("arst_rx_ready", rx_ready, 1);
        check("arst_write", write, 0);
        check("arst_tx_valid", tx_valid, 0);
        check("arst_addr", address_wp, 0);
        check("arst_nbw", numByte_write, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        clr_mon();
        pkt = '{8'h57, 8'h00, 8'h00, 8'h20, 8'h01, 8'hC3};
        send_pkt(pkt);
        do_cs(1'b0, 24'h000020, 8'h01, 3, 10);
        recv(1'b0, b); check("post_rst_status", b, 8'hAA);
        check("post_rst_push_n", push_n, 1);
        check("post_rst_push0", push_log[0], 8'hC3);
        check("post_rst_pulse", wr_hi, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_host_bridge.md
Name: flash_host_bridge

Overview:
- Byte-stream command front-end sitting directly upstream of the SPI flash collection block.
- Parses host packets from a byte source (UART RX or testbench), loads write payload into the collection FIFO through its direct port, and issues read/write request levels with address and length.
- Waits for the flash transaction to finish (CSbar low-then-high), then drains read data from the FIFO to a byte sink with ready/valid.
- Returns a status byte to the host.

Parameters:
- PULSE_LEN, 4, cycles read/write is held high (must be ≥3 for the downstream 2-flop edge detector).
- FIFO_RD_LAT, 1, cycles from direct_rd_en_buf to valid direct_buf_out.
- TIMEOUT, 1000000, max cycles waiting for each CSbar edge before error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  host byte.
- rx_valid  in  1  rx_data valid; consumed when rx_ready=1.
- rx_ready  out  1  bridge accepts a host byte this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid; held until tx_ready.
- tx_ready  in  1  sink accepts tx_data.
- read  out  1  read request level to collection.
- write  out  1  write request level to collection.
- numByte_read_wp  out  8  read byte count.
- numByte_write  out  32  write byte count (zero-extended N).
- address_wp  out  24  flash address.
- direct_fifo  out  1  1 = bridge owns FIFO port.
- direct_buf_in  out  8  FIFO write data.
- direct_wr_en_buf  out  1  FIFO push strobe.
- direct_rd_en_buf  out  1  FIFO pop strobe.
- direct_buf_out  in  8  FIFO read data.
- cs_bar  in  1  monitored flash chip select.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0 except rx_ready=1; state IDLE; counters 0.
- Packet format: OP, A[23:16], A[15:8], A[7:0], N, then N payload bytes (write only). OP 0x57 = write, 0x52 = read. N=0 is illegal.
- rx_ready=1 only in IDLE, ADDR, LEN, and LOAD; 0 elsewhere. A byte is taken when rx_valid & rx_ready.
- IDLE: byte 0x57/0x52 latches opcode and goes to ADDR. Any other byte -> RESP with 0x3F.
- ADDR: three accepted bytes shift into address_wp, MSB first -> LEN.
- LEN:
  - N=0 -> RESP with 0x3F.
  - Otherwise numByte_read_wp=N and numByte_write={24'b0,N}.
  - Write -> LOAD with direct_fifo=1. Read -> START.
- LOAD: each accepted byte drives direct_buf_in=byte and direct_wr_en_buf=1 for exactly that cycle; byte counter increments. After the Nth byte -> START, and direct_fifo drops to 0 on the next cycle.
- START:
  - direct_fifo=0.
  - write (or read) =1 for PULSE_LEN cycles, with address/length stable from at least 1 cycle before the rise until done.
  - Then -> WAIT_LOW.
- WAIT_LOW: wait for cs_bar=0 -> WAIT_HIGH.
- WAIT_HIGH: wait for cs_bar=1 -> write goes to RESP with 0xAA; read goes to POP with direct_fifo=1.
- Timeout: TIMEOUT cycles in WAIT_LOW or WAIT_HIGH without the edge -> RESP with 0xEE; read/write stay 0. The timeout counter resets on each state entry.
- POP: direct_rd_en_buf=1 for one cycle -> CAPTURE.
- CAPTURE: wait FIFO_RD_LAT cycles, register direct_buf_out into tx_data -> SEND.
- SEND: tx_valid=1 until tx_ready. On handshake, if count<N -> POP, else -> RESP with 0xAA.
  - Strictly one pop per handshake; no pop is issued while tx is stalled.
- RESP: tx_data=status, tx_valid=1 until tx_ready -> IDLE. direct_fifo returns to 0 on entry.
- Data bytes always precede the status byte; status is always last.
- rx bytes arriving while rx_ready=0 are not consumed; the source holds them.
- Async rst mid-operation: immediate return to reset values; read/write/direct strobes drop combinationally with the flops; no partial response is sent.
- Counters are 9 bits, so no wrap for N=255.

Test Plan:
- Write: rx 57 01 02 03 02 A5 5A -> two pushes A5, 5A; write high 4 cycles; address_wp=0x010203, numByte_write=2; model pulses cs_bar -> tx AA; busy=0 after.
- Read: rx 52 00 00 10 03; model drops cs_bar 10 cycles, raises 50 cycles later; FIFO preloaded 11 22 33 -> tx 11 22 33 AA, exactly 3 direct_rd_en_buf pulses.
- Backpressure: the read above with tx_ready toggled 1-of-4 cycles -> same byte order, no extra pops, tx_data stable while tx_valid & !tx_ready.
- Illegal: rx 41 -> tx 3F; rx 57 00 00 00 00 -> tx 3F, no write pulse.
- Timeout: TIMEOUT=100, cs_bar held 1 after a read command -> tx EE after 100 cycles, no pops.
- Reset: assert rst during LOAD after 1 of 4 bytes -> all outputs 0 asynchronously, rx_ready=1; a fresh write packet completes normally.
